// File: rtl/data_mem_lsu_pkg.sv
// Shared encodings for the data-memory load/store unit.
package data_mem_lsu_pkg;

  // Access size field
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  // Transaction FSM
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

endpackage

// File: rtl/data_mem_lsu_if.sv
// Request/response bus of the load/store unit.
interface data_mem_lsu_if #(parameter int XLEN = 32);
  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [1:0]      req_size;
  logic            req_unsigned;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_rdata;
  logic            rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering: merges store data into a word and extracts/extends loads.
module mem_lane_align
  import data_mem_lsu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int LW   = $clog2(XLEN/8)
) (
  input  logic [1:0]      size,
  input  logic            uns,
  input  logic [LW-1:0]   lane,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] word,
  output logic [XLEN-1:0] st_word,
  output logic [XLEN-1:0] ld_data
);
  logic [XLEN-1:0] fmask, st_mask, raw;
  logic [LW+2:0]   sh;

  // Store merge keeps untouched lanes; load shifts the lane down and extends it
  always_comb begin
    sh = {lane, 3'b000};
    case (size)
      SZ_BYTE: fmask = XLEN'(8'hFF);
      SZ_HALF: fmask = XLEN'(16'hFFFF);
      default: fmask = XLEN'(32'hFFFF_FFFF);
    endcase
    st_mask = fmask << sh;
    st_word = (word & ~st_mask) | ((wdata << sh) & st_mask);
    raw     = word >> sh;
    case (size)
      SZ_BYTE: ld_data = uns ? XLEN'(raw[7:0])  : XLEN'($signed(raw[7:0]));
      SZ_HALF: ld_data = uns ? XLEN'(raw[15:0]) : XLEN'($signed(raw[15:0]));
      default: ld_data = uns ? XLEN'(raw[31:0]) : XLEN'($signed(raw[31:0]));
    endcase
  end
endmodule

// File: rtl/data_mem_lsu.sv
// Single-outstanding load/store unit over a DEPTH x XLEN register memory.
module data_mem_lsu
  import data_mem_lsu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 64,
  parameter int LATENCY = 1
) (
  input  logic          clk,
  input  logic          reset,
  data_mem_lsu_if.slave bus
);
  localparam int LW = $clog2(XLEN/8);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t          state_q, state_d;
  logic [1:0]      cnt_q, cnt_d;
  logic            we_q, we_d, uns_q, uns_d, err_q, err_d;
  logic [1:0]      size_q, size_d;
  logic [XLEN-1:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [XLEN-1:0] mem_q [DEPTH];

  logic [XLEN-1:0] idx, rd_word, st_word, ld_data;
  logic [AW-1:0]   widx;
  logic            misalign, acc_err, fire, mem_we;

  // Address decode and fault classification of the captured request
  always_comb begin
    idx      = addr_q >> LW;
    widx     = idx[AW-1:0];
    misalign = 1'b0;
    case (size_q)
      SZ_HALF: misalign = addr_q[0];
      SZ_WORD: misalign = |addr_q[1:0];
      default: misalign = 1'b0;
    endcase
    acc_err = (size_q == SZ_RSVD) || misalign || (idx >= XLEN'(DEPTH));
  end

  assign rd_word = mem_q[widx];
  assign fire    = (state_q == WAIT) && (cnt_q == 2'd0);
  assign mem_we  = fire && we_q && !acc_err;

  mem_lane_align #(.XLEN(XLEN)) u_align (
    .size    (size_q),
    .uns     (uns_q),
    .lane    (addr_q[LW-1:0]),
    .wdata   (wdata_q),
    .word    (rd_word),
    .st_word (st_word),
    .ld_data (ld_data)
  );

  // FSM next state: capture on accept, count down, sample result on WAIT exit
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    uns_d   = uns_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (bus.req_valid) begin
        state_d = WAIT;
        cnt_d   = 2'(LATENCY-1);
        we_d    = bus.req_we;
        uns_d   = bus.req_unsigned;
        size_d  = bus.req_size;
        addr_d  = bus.req_addr;
        wdata_d = bus.req_wdata;
      end
      WAIT: if (cnt_q == 2'd0) begin
        state_d = RESP;
        err_d   = acc_err;
        rdata_d = (we_q || acc_err) ? '0 : ld_data;
      end else begin
        cnt_d = cnt_q - 2'd1;
      end
      RESP: if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM and request/response registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= SZ_BYTE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      uns_q   <= uns_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Memory array: cleared on reset, written only by a non-faulting store
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[widx] <= st_word;
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
endmodule

// File: tb/tb_data_mem_lsu.sv
// Randomized and directed bench for data_mem_lsu with LATENCY=1 and LATENCY=3 instances.
module tb_data_mem_lsu;
  import data_mem_lsu_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Index 0 drives the LATENCY=1 DUT, index 1 the LATENCY=3 DUT
  logic [1:0]       rv = '0, rwe = '0, run = '0, rr = '0;
  logic [1:0][1:0]  rsz = '0;
  logic [1:0][31:0] ra = '0, rwd = '0;
  logic [1:0]       rqr, rsv, rse;
  logic [1:0][31:0] rsd;

  data_mem_lsu_if #(.XLEN(32)) bus0 ();
  data_mem_lsu_if #(.XLEN(32)) bus1 ();

  assign bus0.req_valid = rv[0];  assign bus1.req_valid = rv[1];
  assign bus0.req_we = rwe[0];    assign bus1.req_we = rwe[1];
  assign bus0.req_unsigned = run[0]; assign bus1.req_unsigned = run[1];
  assign bus0.req_size = rsz[0];  assign bus1.req_size = rsz[1];
  assign bus0.req_addr = ra[0];   assign bus1.req_addr = ra[1];
  assign bus0.req_wdata = rwd[0]; assign bus1.req_wdata = rwd[1];
  assign bus0.rsp_ready = rr[0];  assign bus1.rsp_ready = rr[1];
  assign rqr = {bus1.req_ready, bus0.req_ready};
  assign rsv = {bus1.rsp_valid, bus0.rsp_valid};
  assign rse = {bus1.rsp_err, bus0.rsp_err};
  assign rsd = {bus1.rsp_rdata, bus0.rsp_rdata};

  data_mem_lsu #(.XLEN(32), .DEPTH(64), .LATENCY(1)) u_dut1 (.clk(clk), .reset(reset), .bus(bus0));
  data_mem_lsu #(.XLEN(32), .DEPTH(64), .LATENCY(3)) u_dut3 (.clk(clk), .reset(reset), .bus(bus1));

  // Reference model: byte-addressed memory per DUT
  logic [7:0] mem_m [2][256];

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  task automatic model_clear();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 256; i++) mem_m[d][i] = 8'h00;
  endtask

  task automatic model_op(input int d, input bit we, input logic [1:0] sz, input bit un,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er);
    int nb;
    logic [31:0] v;
    nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    er = (sz == 2'd3) || ((a % nb) != 0) || ((a / 4) >= 64);
    rd = 32'h0;
    if (er) return;
    if (we) begin
      for (int i = 0; i < nb; i++) mem_m[d][a + i] = wd[8*i +: 8];
    end else begin
      v = 32'h0;
      for (int i = 0; i < nb; i++) v[8*i +: 8] = mem_m[d][a + i];
      if (!un && v[8*nb-1])
        for (int i = nb; i < 4; i++) v[8*i +: 8] = 8'hFF;
      rd = v;
    end
  endtask

  // Full transaction: accept, latency measurement, held response, handshake
  task automatic do_txn(input int d, input bit we, input logic [1:0] sz, input bit un,
                        input logic [31:0] a, input logic [31:0] wd, input int hold,
                        output logic [31:0] rd, output logic er);
    int lat;
    bit busy_rdy;
    @(negedge clk);
    checks++;
    if (rqr[d] !== 1'b1) begin
      errors++; $display("FAIL accept_ready d=%0d got %b want 1", d, rqr[d]);
    end
    rv[d] = 1'b1; rwe[d] = we; rsz[d] = sz; run[d] = un; ra[d] = a; rwd[d] = wd;
    @(posedge clk); #1;
    // Inputs change after accept and must have no effect
    rv[d] = 1'b0; rwe[d] = ~we; rsz[d] = $urandom_range(0, 3); run[d] = ~un;
    ra[d] = $urandom; rwd[d] = $urandom;
    lat = 0; busy_rdy = 1'b0;
    while (rsv[d] !== 1'b1 && lat < 20) begin
      if (rqr[d] !== 1'b0) busy_rdy = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat != lat_of(d)) begin
      errors++; $display("FAIL latency d=%0d got %0d want %0d", d, lat, lat_of(d));
    end
    checks++;
    if (busy_rdy || rqr[d] !== 1'b0) begin
      errors++; $display("FAIL busy_ready d=%0d got 1 want 0", d);
    end
    rd = rsd[d]; er = rse[d];
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      checks++;
      if (rsv[d] !== 1'b1 || rsd[d] !== rd || rse[d] !== er || rqr[d] !== 1'b0) begin
        errors++;
        $display("FAIL hold d=%0d got v=%b rd=%h rdy=%b want v=1 rd=%h rdy=0", d, rsv[d], rsd[d], rqr[d], rd);
      end
    end
    @(negedge clk); rr[d] = 1'b1;
    @(posedge clk); #1; rr[d] = 1'b0;
    checks++;
    if (rsv[d] !== 1'b0 || rqr[d] !== 1'b1) begin
      errors++; $display("FAIL handshake_exit d=%0d got v=%b rdy=%b want v=0 rdy=1", d, rsv[d], rqr[d]);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (rqr !== 2'b11 || rsv !== 2'b00 || rse !== 2'b00 || rsd !== '0) begin
      errors++; $display("FAIL reset_state got rdy=%b v=%b e=%b rd=%h want rdy=11 v=00 e=00 rd=0", rqr, rsv, rse, rsd);
    end
  endtask

  task automatic test_directed();
    logic [31:0] rd, xr; logic er, xe;
    model_op(0, 1, SZ_WORD, 0, 32'h10, 32'hDEADBEEF, xr, xe);
    do_txn(0, 1, SZ_WORD, 0, 32'h10, 32'hDEADBEEF, 0, rd, er);
    checks++; if (rd !== 32'h0 || er !== 1'b0) begin errors++; $display("FAIL st_word got rd=%h e=%b want 0 0", rd, er); end
    model_op(0, 0, SZ_WORD, 0, 32'h10, 32'h0, xr, xe);
    do_txn(0, 0, SZ_WORD, 0, 32'h10, 32'h0, 0, rd, er);
    checks++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin errors++; $display("FAIL ld_word got rd=%h e=%b want deadbeef 0", rd, er); end
    model_op(0, 1, SZ_BYTE, 0, 32'h11, 32'h80, xr, xe);
    do_txn(0, 1, SZ_BYTE, 0, 32'h11, 32'h80, 0, rd, er);
    do_txn(0, 0, SZ_BYTE, 0, 32'h11, 32'h0, 1, rd, er);
    checks++; if (rd !== 32'hFFFFFF80 || er !== 1'b0) begin errors++; $display("FAIL ld_byte_s got rd=%h want ffffff80", rd); end
    do_txn(0, 0, SZ_BYTE, 1, 32'h11, 32'h0, 0, rd, er);
    checks++; if (rd !== 32'h00000080 || er !== 1'b0) begin errors++; $display("FAIL ld_byte_u got rd=%h want 00000080", rd); end
    do_txn(0, 0, SZ_WORD, 0, 32'h10, 32'h0, 0, rd, er);
    checks++; if (rd !== 32'hDEAD80EF) begin errors++; $display("FAIL ld_merged got rd=%h want dead80ef", rd); end
    do_txn(0, 1, SZ_HALF, 0, 32'h13, 32'h5555, 0, rd, er);
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL st_misalign got e=%b rd=%h want 1 0", er, rd); end
    do_txn(0, 0, SZ_WORD, 0, 32'h10, 32'h0, 0, rd, er);
    checks++; if (rd !== 32'hDEAD80EF) begin errors++; $display("FAIL mem_unchanged got rd=%h want dead80ef", rd); end
    do_txn(0, 0, SZ_WORD, 0, 32'h100, 32'h0, 0, rd, er);
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL ld_range got e=%b rd=%h want 1 0", er, rd); end
    do_txn(0, 0, SZ_RSVD, 0, 32'h10, 32'h0, 0, rd, er);
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL ld_rsvd got e=%b rd=%h want 1 0", er, rd); end
  endtask

  task automatic test_latency3();
    logic [31:0] rd, xr; logic er, xe;
    model_op(1, 1, SZ_WORD, 0, 32'h40, 32'hCAFEF00D, xr, xe);
    do_txn(1, 1, SZ_WORD, 0, 32'h40, 32'hCAFEF00D, 5, rd, er);
    model_op(1, 0, SZ_HALF, 0, 32'h42, 32'h0, xr, xe);
    do_txn(1, 0, SZ_HALF, 0, 32'h42, 32'h0, 5, rd, er);
    checks++; if (rd !== 32'hFFFFCAFE || er !== 1'b0) begin errors++; $display("FAIL lat3_ld_half got rd=%h want ffffcafe", rd); end
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd; logic er; int seen;
    @(negedge clk);
    rv[1] = 1'b1; rwe[1] = 1'b1; rsz[1] = SZ_WORD; ra[1] = 32'h20; rwd[1] = 32'h12345678; run[1] = 1'b0;
    @(posedge clk); #1; rv[1] = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0; model_clear();
    seen = 0;
    for (int i = 0; i < 5; i++) begin @(posedge clk); #1; if (rsv[1] !== 1'b0) seen++; end
    checks++; if (seen != 0 || rqr[1] !== 1'b1) begin errors++; $display("FAIL abort_no_rsp got %0d rsp cycles want 0", seen); end
    do_txn(1, 0, SZ_WORD, 0, 32'h20, 32'h0, 0, rd, er);
    checks++; if (rd !== 32'h0 || er !== 1'b0) begin errors++; $display("FAIL abort_no_write got rd=%h want 0", rd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] xa, xb; logic ea, eb; int lat;
    model_op(0, 1, SZ_WORD, 0, 32'h08, 32'hA5A55A5A, xa, ea);
    model_op(0, 0, SZ_BYTE, 1, 32'h0B, 32'h0, xa, ea);
    model_op(0, 0, SZ_HALF, 0, 32'h08, 32'h0, xb, eb);
    do_txn(0, 1, SZ_WORD, 0, 32'h08, 32'hA5A55A5A, 0, xa, ea);
    model_op(0, 0, SZ_BYTE, 1, 32'h0B, 32'h0, xa, ea);
    // req_valid stays high: first load, then second load presented immediately after accept
    @(negedge clk); rv[0] = 1'b1; rwe[0] = 1'b0; rsz[0] = SZ_BYTE; run[0] = 1'b1; ra[0] = 32'h0B;
    @(posedge clk); #1; rsz[0] = SZ_HALF; run[0] = 1'b0; ra[0] = 32'h08;
    lat = 0;
    while (rsv[0] !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
    @(posedge clk); #1;
    checks++;
    if (rsv[0] !== 1'b1 || rqr[0] !== 1'b0 || rsd[0] !== xa) begin
      errors++; $display("FAIL b2b_first got v=%b rdy=%b rd=%h want 1 0 %h", rsv[0], rqr[0], rsd[0], xa);
    end
    @(negedge clk); rr[0] = 1'b1;
    @(posedge clk); #1; rr[0] = 1'b0;
    checks++; if (rsv[0] !== 1'b0 || rqr[0] !== 1'b1) begin errors++; $display("FAIL b2b_gap got v=%b rdy=%b want 0 1", rsv[0], rqr[0]); end
    @(posedge clk); #1; rv[0] = 1'b0;
    checks++; if (rqr[0] !== 1'b0) begin errors++; $display("FAIL b2b_second_accept got rdy=%b want 0", rqr[0]); end
    lat = 0;
    while (rsv[0] !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
    checks++; if (rsd[0] !== xb || rse[0] !== eb) begin errors++; $display("FAIL b2b_second got rd=%h e=%b want %h %b", rsd[0], rse[0], xb, eb); end
    @(negedge clk); rr[0] = 1'b1;
    @(posedge clk); #1; rr[0] = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] a, wd, rd, xr; logic [1:0] sz; logic er, xe; bit we, un; int nb;
    for (int n = 0; n < 300; n++) begin
      int d;
      d = n % 2;
      we = $urandom_range(0, 1); un = $urandom_range(0, 1);
      sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      a = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(250, 300)) : 32'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) a = a & ~(32'(nb) - 32'd1);
      wd = $urandom;
      model_op(d, we, sz, un, a, wd, xr, xe);
      do_txn(d, we, sz, un, a, wd, $urandom_range(0, 2), rd, er);
      checks++;
      if (rd !== xr || er !== xe) begin
        errors++;
        $display("FAIL random n=%0d d=%0d we=%0d sz=%0d a=%h got rd=%h e=%b want rd=%h e=%b", n, d, we, sz, a, rd, er, xr, xe);
      end
    end
  endtask

  initial begin
    model_clear();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    test_reset();
    test_directed();
    test_latency3();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound so the run always terminates
  initial begin
    #2000000;
    $display("FAIL timeout got no finish want finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/data_mem_lsu.md
DATA_MEM_LSU -- requirements
Module: data_mem_lsu

Interface
REQ-001 Parameter XLEN, default 32, data/address width in bits (multiple of 8).
REQ-002 Parameter DEPTH, default 64, number of XLEN-bit memory words.
REQ-003 Parameter LATENCY, default 1, range 1..4: cycles from request accept to rsp_valid.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 req_valid  input  1  request present.
REQ-007 req_ready  output  1  block can accept a request this cycle.
REQ-008 req_we  input  1  1 = store, 0 = load.
REQ-009 req_size  input  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-010 req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-011 req_addr  input  XLEN  byte address.
REQ-012 req_wdata  input  XLEN  store data, right-aligned.
REQ-013 rsp_valid  output  1  response present.
REQ-014 rsp_ready  input  1  consumer accepts response.
REQ-015 rsp_rdata  output  XLEN  extended load data; 0 for stores and errors.
REQ-016 rsp_err  output  1  access faulted (misaligned, out of range or reserved size).

Function
REQ-017 FSM states: IDLE, WAIT, RESP. req_ready SHALL be 1 only in IDLE.
REQ-018 Accept occurs when req_valid && req_ready; all request fields are registered on accept, and input changes afterwards have no effect.
REQ-019 IDLE->WAIT on accept; a latency counter loads LATENCY-1.
REQ-020 WAIT->RESP when the counter is 0; otherwise the counter decrements. rsp_valid rises exactly LATENCY cycles after the accept edge.
REQ-021 The store write and load read-sample occur on the WAIT->RESP edge. rsp_rdata and rsp_err are registered and stable throughout RESP.
REQ-022 RESP->IDLE when rsp_ready=1; rsp_valid holds until then. The next accept is no earlier than the cycle after the RESP exit (no overlap).
REQ-023 Word index = addr >> log2(XLEN/8). Byte lane = the low address bits.
REQ-024 Misalignment: half with addr[0]=1, or word with addr[1:0]!=0, SHALL set rsp_err.
REQ-025 Index >= DEPTH, or req_size=11, SHALL set rsp_err.
REQ-026 An erroring store SHALL NOT modify memory. An erroring load SHALL return rsp_rdata=0.
REQ-027 Byte/half stores SHALL modify only the addressed lanes; other lanes of the word are preserved.
REQ-028 Loads SHALL extract the addressed lane(s) and sign- or zero-extend them to XLEN per req_unsigned.
REQ-029 A load following a store to the same address SHALL return the stored data.

Reset
REQ-030 Reset SHALL force state=IDLE, the counter to 0, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, and every memory word to 0.
REQ-031 Reset asserted in WAIT or RESP SHALL abort the transaction with no write and no response.
REQ-032 req_ready SHALL first be usable in the first cycle after reset deasserts.

Structure
REQ-033 A shared package SHALL hold the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the state enum (IDLE, WAIT, RESP).
REQ-034 Lane steering and extension SHALL live in a combinational sub-module mem_lane_align: store-merge path and load-extract/extend path.
REQ-035 Memory SHALL be a DEPTH x XLEN register array inside data_mem_lsu.

Verification (XLEN=32, DEPTH=64)
REQ-036 LATENCY=1: store word 0xDEADBEEF @0x10, then load word @0x10 -> rsp_valid 1 cycle after each accept; rdata=0xDEADBEEF; err=0.
REQ-037 Store byte 0x80 @0x11, then load byte signed @0x11 -> 0xFFFFFF80; unsigned -> 0x00000080; load word @0x10 -> 0xDEAD80EF.
REQ-038 Half store @0x13 -> err=1 and memory unchanged. Word load @0x100 (index 64) -> err=1, rdata=0.
REQ-039 LATENCY=3, rsp_ready held low 5 cycles -> rsp_valid exactly 3 cycles after accept; rsp_valid and rdata held; req_ready=0 until the handshake completes.
REQ-040 Reset pulsed during WAIT of a store 0x12345678 @0x20 -> no response; a following load @0x20 returns 0.
REQ-041 req_size=11 load -> err=1, rdata=0. Back-to-back requests -> each accepted only after the previous RESP exit.
